// File: rtl/ads42_spi_arbiter.sv
// ads42_spi_arbiter: round-robin sharing of one ads42_spi_master between two command
// sources, with read-byte routing, an inter-frame gap and a watchdog on o_spi_done.
module ads42_spi_arbiter #(
  parameter int unsigned DATA_WITH   = 16,
  parameter int unsigned RDATA_WITH  = 8,
  parameter int unsigned CNT_WITH    = 8,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic [DATA_WITH-1:0]  i_dat0,
  input  logic [DATA_WITH-1:0]  i_dat1,
  input  logic [CNT_WITH-1:0]   i_cnt0,
  input  logic [CNT_WITH-1:0]   i_cnt1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic                  o_done0,
  output logic                  o_done1,
  output logic                  o_err0,
  output logic                  o_err1,
  output logic [RDATA_WITH-1:0] o_rdat0,
  output logic [RDATA_WITH-1:0] o_rdat1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic                  o_busy,
  output logic [DATA_WITH-1:0]  o_dat_in,
  output logic                  o_opt_start,
  output logic [CNT_WITH-1:0]   o_opt_cnt,
  input  logic [RDATA_WITH-1:0] i_dat_out,
  input  logic                  i_dat_vaild,
  input  logic                  i_spi_done
);

  localparam int unsigned WdW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYC - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StGap} state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [DATA_WITH-1:0]  dat_in_q, dat_in_d;
  logic [CNT_WITH-1:0]   opt_cnt_q, opt_cnt_d;
  logic                  opt_start_q, opt_start_d;
  logic                  busy_q, busy_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [RDATA_WITH-1:0] rdat0_q, rdat0_d;
  logic [RDATA_WITH-1:0] rdat1_q, rdat1_d;

  logic       grant1;
  logic [1:0] own_oh;

  // With both requesting, the port that did not win last time goes next.
  assign grant1 = i_req1 && (!i_req0 || !ptr_q);
  assign own_oh = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    dat_in_d    = dat_in_q;
    opt_cnt_d   = opt_cnt_q;
    opt_start_d = 1'b0;
    busy_d      = busy_q;
    ack_d       = 2'b00;
    done_d      = 2'b00;
    err_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdat0_d     = rdat0_q;
    rdat1_d     = rdat1_q;
    unique case (state_q)
      StIdle: begin
        if (i_req0 || i_req1) begin
          owner_d   = grant1;
          ptr_d     = grant1;
          dat_in_d  = grant1 ? i_dat1 : i_dat0;
          opt_cnt_d = grant1 ? i_cnt1 : i_cnt0;
          ack_d     = grant1 ? 2'b10 : 2'b01;
          busy_d    = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        opt_start_d = 1'b1;
        wd_d        = '0;
        state_d     = StBusy;
      end
      StBusy: begin
        if (i_dat_vaild) begin
          rvalid_d = own_oh;
          if (owner_q) rdat1_d = i_dat_out;
          else         rdat0_d = i_dat_out;
        end
        if (i_spi_done) begin
          done_d  = own_oh;
          gap_d   = '0;
          state_d = StGap;
        end else if (wd_q == WdLast) begin
          done_d  = own_oh;
          err_d   = own_oh;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b1;
      owner_q     <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
      dat_in_q    <= '0;
      opt_cnt_q   <= '0;
      opt_start_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdat0_q     <= '0;
      rdat1_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      dat_in_q    <= dat_in_d;
      opt_cnt_q   <= opt_cnt_d;
      opt_start_q <= opt_start_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      rdat0_q     <= rdat0_d;
      rdat1_q     <= rdat1_d;
    end
  end

  assign o_ack0      = ack_q[0];
  assign o_ack1      = ack_q[1];
  assign o_done0     = done_q[0];
  assign o_done1     = done_q[1];
  assign o_err0      = err_q[0];
  assign o_err1      = err_q[1];
  assign o_rvalid0   = rvalid_q[0];
  assign o_rvalid1   = rvalid_q[1];
  assign o_rdat0     = rdat0_q;
  assign o_rdat1     = rdat1_q;
  assign o_busy      = busy_q;
  assign o_dat_in    = dat_in_q;
  assign o_opt_start = opt_start_q;
  assign o_opt_cnt   = opt_cnt_q;

endmodule
